// File: rtl/alu_seq16.sv
// rtl/alu_seq16.sv - multi-cycle 16-bit op / 8x8 multiply sequencer over an external 8-bit ALU
//
// Purpose:
//   Accepts one request at a time and drives an external 8-bit ALU over
//   several cycles to build a 16-bit result.
//   - ADD16 / AND16 / OR16 take a low-byte pass and then a high-byte pass.
//   - MUL8 runs shift-and-add over the 8 multiplier bits. Each set bit costs
//     a two-pass 16-bit accumulate.
//   The carry between passes is held here, not in the ALU.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_op[1:0]                   0=ADD16 1=AND16 2=OR16 3=MUL8
//   req_a[15:0], req_b[15:0]      operands (MUL8 uses [7:0])
//   resp_valid/resp_ready         response handshake
//   resp_result[15:0]             result
//   resp_carry, resp_zero         carry out of bit 15 (ADD16), result==0
//   alu_ctrl[2:0]                 ALU op: 0=ADD 1=ADDC 2=AND 3=OR
//   alu_a[7:0], alu_b[7:0]        ALU operands
//   alu_cin                       ALU carry in
//   alu_out[7:0], alu_cout        ALU result and carry out

module alu_seq16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_result,
  output logic        resp_carry,
  output logic        resp_zero,
  output logic [2:0]  alu_ctrl,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout
);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_ADDC = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_MUL_CHK,
    S_MUL_LO,
    S_MUL_HI,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [2:0]  r_cnt;
  logic        r_carry;
  logic [15:0] r_res;
  logic        r_zero;

  logic [2:0]  w_op_ctrl;
  logic        w_is_add;
  logic [15:0] w_add_res;
  logic [15:0] w_mul_acc;

  assign w_is_add  = (r_op == OP_ADD);
  // Full values as they stand at the end of the final pass, used to derive the zero flag.
  assign w_add_res = {alu_out, r_res[7:0]};
  assign w_mul_acc = {alu_out, r_acc[7:0]};

  always_comb begin
    w_op_ctrl = ALU_ADD;
    case (r_op)
      OP_AND:  w_op_ctrl = ALU_AND;
      OP_OR:   w_op_ctrl = ALU_OR;
      default: w_op_ctrl = ALU_ADD;
    endcase
  end

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_DONE);
  assign resp_result = r_res;
  assign resp_carry  = r_carry;
  assign resp_zero   = r_zero;

  // ALU drive is decoded from the current state so the ALU answers within the same cycle.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_cin  = 1'b0;
    case (r_state)
      S_LO: begin
        alu_ctrl = w_op_ctrl;
        alu_a    = r_a[7:0];
        alu_b    = r_b[7:0];
      end
      S_HI: begin
        alu_ctrl = w_is_add ? ALU_ADDC : w_op_ctrl;
        alu_a    = r_a[15:8];
        alu_b    = r_b[15:8];
        alu_cin  = w_is_add & r_carry;
      end
      S_MUL_LO: begin
        alu_ctrl = ALU_ADD;
        alu_a    = r_acc[7:0];
        alu_b    = r_mcand[7:0];
      end
      S_MUL_HI: begin
        alu_ctrl = ALU_ADDC;
        alu_a    = r_acc[15:8];
        alu_b    = r_mcand[15:8];
        alu_cin  = r_carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= 2'd0;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_acc    <= 16'h0000;
      r_mcand  <= 16'h0000;
      r_mplier <= 8'h00;
      r_cnt    <= 3'd0;
      r_carry  <= 1'b0;
      r_res    <= 16'h0000;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op <= req_op;
            r_a  <= req_a;
            r_b  <= req_b;
            if (req_op == OP_MUL) begin
              r_acc    <= 16'h0000;
              r_mcand  <= {8'h00, req_a[7:0]};
              r_mplier <= req_b[7:0];
              r_cnt    <= 3'd0;
              r_state  <= S_MUL_CHK;
            end else begin
              r_state <= S_LO;
            end
          end
        end
        S_LO: begin
          r_res[7:0] <= alu_out;
          r_carry    <= w_is_add & alu_cout;
          r_state    <= S_HI;
        end
        S_HI: begin
          r_res[15:8] <= alu_out;
          r_carry     <= w_is_add & alu_cout;
          r_zero      <= (w_add_res == 16'h0000);
          r_state     <= S_DONE;
        end
        S_MUL_CHK: begin
          if (r_mplier[0]) begin
            r_state <= S_MUL_LO;
          end else begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_res   <= r_acc;
              r_zero  <= (r_acc == 16'h0000);
              r_carry <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_MUL_LO: begin
          r_acc[7:0] <= alu_out;
          r_carry    <= alu_cout;
          r_state    <= S_MUL_HI;
        end
        S_MUL_HI: begin
          r_acc[15:8] <= alu_out;
          r_mcand     <= r_mcand << 1;
          r_mplier    <= r_mplier >> 1;
          r_cnt       <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            // The product fits in 16 bits, so the response carry is always clear.
            r_res   <= w_mul_acc;
            r_zero  <= (w_mul_acc == 16'h0000);
            r_carry <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_MUL_CHK;
          end
        end
        S_DONE: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq16.md
Name: alu_seq16

Overview:
- Multi-cycle sequencer that drives one 8-bit ALU instance (ALU_def/ALU_CTRL op set) to execute 16-bit operations and an 8x8 unsigned multiply.
- Owns the carry register between low and high byte passes: the ALU's cin comes from the sequencer, and the ALU's cout is captured by the sequencer.
- Sits between the issue stage (valid/ready request) and the ALU. It returns a 16-bit result with carry and zero flags over a valid/ready response channel.

Parameters:
- none; datapath fixed at 16-bit operands over an 8-bit ALU.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_op  input  2  operation: 0=ADD16, 1=AND16, 2=OR16, 3=MUL8.
- req_a  input  16  operand A; MUL8 uses [7:0] only.
- req_b  input  16  operand B; MUL8 uses [7:0] only.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer takes result.
- resp_result  output  16  result.
- resp_carry  output  1  carry out of bit 15 (ADD16 only; 0 otherwise).
- resp_zero  output  1  resp_result == 16'h0000.
- alu_ctrl  output  ALU_CTRL  ALU operation select.
- alu_a  output  8  ALU operand a.
- alu_b  output  8  ALU operand b.
- alu_cin  output  1  ALU carry in.
- alu_out  input  8  ALU result.
- alu_cout  input  1  ALU carry out.

Behaviour:
- Reset (asynchronous, any state): state=IDLE.
  - Operand, accumulator, result and carry registers are cleared.
  - resp_valid=0, resp_result=0, resp_carry=0, resp_zero=0; req_ready=1.
  - In-flight operation is discarded with no response.
- Outside LO/HI/MUL_LO/MUL_HI: alu_ctrl=ALU_ADD, alu_a=0, alu_b=0, alu_cin=0.
- IDLE: req_ready=1.
  - On req_valid&&req_ready, latch op, a and b.
  - ADD16/AND16/OR16 go to LO.
  - MUL8 goes to MUL_CHK with acc=0, mcand={8'h00,a[7:0]}, mplier=b[7:0], cnt=0.
- LO: alu_a=a[7:0], alu_b=b[7:0], alu_cin=0; alu_ctrl=ALU_ADD / ALU_AND / ALU_OR per op.
  - Register res[7:0]<=alu_out and carry_r<=alu_cout (ADD16 only; else 0).
  - Next state HI.
- HI: alu_a=a[15:8], alu_b=b[15:8].
  - ADD16 uses alu_ctrl=ALU_ADDC, alu_cin=carry_r. AND16/OR16 use the same op as LO with cin=0.
  - Register res[15:8]<=alu_out and carry_r<=alu_cout (ADD16 only).
  - Next state DONE.
- MUL_CHK:
  - If mplier[0]=1, go to MUL_LO.
  - Else do the shift step: mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1. If cnt==7 go to DONE, else stay in MUL_CHK.
- MUL_LO: alu_ctrl=ALU_ADD, alu_a=acc[7:0], alu_b=mcand[7:0].
  - acc[7:0]<=alu_out, carry_r<=alu_cout.
  - Next state MUL_HI.
- MUL_HI: alu_ctrl=ALU_ADDC, alu_a=acc[15:8], alu_b=mcand[15:8], alu_cin=carry_r.
  - acc[15:8]<=alu_out, then the shift step.
  - If cnt==7 go to DONE, else MUL_CHK.
  - MUL8 result=acc; resp_carry=0 (the product always fits in 16 bits).
- DONE: resp_valid=1.
  - resp_result, resp_carry and resp_zero are held stable until resp_ready=1; on that cycle's edge go to IDLE.
  - req_ready=0, and req_valid is ignored, in every state except IDLE.
- Latency, handshake edge to the first cycle with resp_valid=1:
  - ADD16/AND16/OR16: 3 cycles.
  - MUL8: 8+2*popcount(b[7:0])+1 cycles (minimum 9, maximum 25).
- There is no back-to-back acceptance: a new request is accepted no earlier than the cycle after the response handshake.
- resp_zero is derived from the 16-bit result. It does not come from the ALU zero flag.

Test Plan:
1. ADD16 a=16'h00FF, b=16'h0001 -> result 16'h0100, carry=0, zero=0, resp_valid 3 cycles after accept; alu_cin=1 observed in HI. ADD16 16'hFFFF+16'h0001 -> result 16'h0000, carry=1, zero=1.
2. AND16 16'hF0F0 & 16'h3C3C -> result 16'h3030, carry=0. OR16 16'hF0F0 | 16'h0F0F -> result 16'hFFFF.
3. MUL8 a=8'h0F, b=8'h0D -> result 16'h00C3 after 15 cycles. MUL8 8'hFF*8'hFF -> result 16'hFE01 after 25 cycles, carry=0. MUL8 b=0 -> result 16'h0000, zero=1 after 9 cycles.
4. Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 -> result and flags stable, req_ready=0, no second accept. Raise resp_ready -> IDLE next cycle, then the new request is accepted.
5. Assert rst_n=0 mid-MUL8 (in MUL_HI) -> all outputs zero immediately, req_ready=1. After release, ADD16 16'h1234+16'h1111 -> result 16'h2345.
6. Upper operand bytes are ignored for MUL8: a=16'hAB03, b=16'hCD05 -> result 16'h000F.
